// File: rtl/fd_pulse_delay_array.sv
// Multi-channel programmable pulse delay generator with optional LFSR jitter.
// Each channel timestamps rising edges and replays them in order after a delay.
module fd_pulse_delay_array #(
    parameter int unsigned g_NUM_CHANNELS = 4,
    parameter int unsigned g_DELAY_WIDTH  = 16,
    parameter int unsigned g_FIFO_DEPTH   = 8,
    parameter int unsigned g_JITTER_BITS  = 3,
    parameter logic [15:0] g_LFSR_SEED    = 16'hACE1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [g_NUM_CHANNELS-1:0]               pulse_i,
    input  logic [g_NUM_CHANNELS-1:0]               enable_i,
    input  logic [g_NUM_CHANNELS*g_DELAY_WIDTH-1:0] delay_i,
    input  logic [g_NUM_CHANNELS-1:0]               jitter_en_i,
    input  logic [g_NUM_CHANNELS-1:0]               overflow_clr_i,
    output logic [g_NUM_CHANNELS-1:0]               pulse_o,
    output logic [g_NUM_CHANNELS-1:0]               busy_o,
    output logic [g_NUM_CHANNELS-1:0]               overflow_o
);
    localparam int N  = g_NUM_CHANNELS;
    localparam int W  = g_DELAY_WIDTH;
    localparam int J  = g_JITTER_BITS;
    localparam int TW = W + 1;
    localparam int AW = $clog2(g_FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef logic [TW-1:0] ts_t;

    localparam ts_t           HALF     = ts_t'(1) << W;
    localparam logic [CW-1:0] CNT_FULL = CW'(g_FIFO_DEPTH);

    ts_t          tc_q, tc_d;
    logic [15:0]  lfsr_q, lfsr_d;
    logic [N-1:0] pulse_prev_q, pulse_prev_d;

    always_comb begin
        tc_d         = tc_q + ts_t'(1);
        lfsr_d       = {lfsr_q[14:0],
                        lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        pulse_prev_d = pulse_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tc_q         <= '0;
            lfsr_q       <= g_LFSR_SEED;
            pulse_prev_q <= '0;
        end else begin
            tc_q         <= tc_d;
            lfsr_q       <= lfsr_d;
            pulse_prev_q <= pulse_prev_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_ch
        ts_t           mem_q [g_FIFO_DEPTH];
        ts_t           mem_d [g_FIFO_DEPTH];
        logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          pls_q, pls_d, busy_q, busy_d, ovf_q, ovf_d;
        logic [J-1:0]  jit;
        ts_t           due;
        logic          ev, full, rel, push, drop;

        always_comb begin
            jit  = J'({lfsr_q, lfsr_q} >> k);
            // Stored stamp is the pop cycle; the output register adds one more.
            due  = tc_q + ts_t'(delay_i[k*W +: W]) + ts_t'(2);
            if (jitter_en_i[k]) due = due + ts_t'(jit);
            ev   = pulse_i[k] & ~pulse_prev_q[k];
            full = (cnt_q == CNT_FULL);
            rel  = enable_i[k] && (cnt_q != '0)
                   && ((tc_q - mem_q[rd_q]) < HALF);
            push = enable_i[k] && ev && (!full || rel);
            drop = enable_i[k] && ev && full && !rel;

            mem_d = mem_q;
            wr_d  = wr_q;
            rd_d  = rd_q;
            cnt_d = cnt_q;
            if (push) begin
                mem_d[wr_q] = due;
                wr_d        = wr_q + AW'(1);
            end
            if (rel) rd_d = rd_q + AW'(1);
            if (push && !rel) cnt_d = cnt_q + CW'(1);
            else if (rel && !push) cnt_d = cnt_q - CW'(1);
            if (!enable_i[k]) begin
                wr_d  = '0;
                rd_d  = '0;
                cnt_d = '0;
            end

            pls_d  = rel;
            busy_d = rel || (cnt_d != '0);
            ovf_d  = drop || (ovf_q && !overflow_clr_i[k]);
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                mem_q  <= '{default: '0};
                wr_q   <= '0;
                rd_q   <= '0;
                cnt_q  <= '0;
                pls_q  <= 1'b0;
                busy_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                mem_q  <= mem_d;
                wr_q   <= wr_d;
                rd_q   <= rd_d;
                cnt_q  <= cnt_d;
                pls_q  <= pls_d;
                busy_q <= busy_d;
                ovf_q  <= ovf_d;
            end
        end

        assign pulse_o[k]    = pls_q;
        assign busy_o[k]     = busy_q;
        assign overflow_o[k] = ovf_q;
    end
endmodule

// File: tb/tb_fd_pulse_delay_array.sv
// Bench for fd_pulse_delay_array: vector table plus scoreboarded sequences.
// W is reduced to 12 so the timestamp wrap is reachable in a short run.
module tb_fd_pulse_delay_array;
    localparam int N = 4;
    localparam int W = 12;
    localparam int D = 8;
    localparam int J = 3;
    localparam int WRAP_TC = 2**(W+1) - 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   pulse_i = '0;
    logic [N-1:0]   enable_i = '0;
    logic [N*W-1:0] delay_i = '0;
    logic [N-1:0]   jitter_en_i = '0;
    logic [N-1:0]   overflow_clr_i = '0;
    logic [N-1:0]   pulse_o, busy_o, overflow_o;

    fd_pulse_delay_array #(
        .g_NUM_CHANNELS(N),
        .g_DELAY_WIDTH (W),
        .g_FIFO_DEPTH  (D),
        .g_JITTER_BITS (J),
        .g_LFSR_SEED   (16'hACE1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pulse_i       (pulse_i),
        .enable_i      (enable_i),
        .delay_i       (delay_i),
        .jitter_en_i   (jitter_en_i),
        .overflow_clr_i(overflow_clr_i),
        .pulse_o       (pulse_o),
        .busy_o        (busy_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct { int exp; int ev; } sb_t;
    typedef struct { int ch; int d; int lat; } vec_t;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          r0, t;
    bit          jlog_on = 1'b0;
    sb_t         sbq [N][$];
    int          jlat [$];
    int          run1 [$];
    logic [15:0] m_lfsr;
    vec_t        vecs [7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[14:0],
                        m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: cyc %0d got %0d expected %0d",
                     name, cyc, got, exp);
        end
    endtask

    // Advance one cycle and score any strobes seen in the new cycle.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (pulse_o[k]) begin
                    if (sbq[k].size() == 0) begin
                        check($sformatf("spurious_ch%0d", k), 1, 0);
                    end else begin
                        e = sbq[k].pop_front();
                        check($sformatf("strobe_ch%0d", k), cyc, e.exp);
                        if (jlog_on && k == 2) jlat.push_back(cyc - e.ev);
                    end
                end
            end
        end
    endtask

    task automatic fire(input int ch, input int d, input bit jen,
                        input bit push, input int lat);
        sb_t e;
        delay_i[ch*W +: W] = W'(d);
        jitter_en_i[ch]    = jen;
        pulse_i[ch]        = 1'b1;
        if (push) begin
            e.ev  = cyc;
            e.exp = cyc + lat;
            sbq[ch].push_back(e);
        end
        tick();
        pulse_i[ch] = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()
                + sbq[3].size()) != 0 && n < maxc) begin
            tick();
            n++;
        end
        for (int k = 0; k < N; k++)
            check($sformatf("missing_ch%0d", k), sbq[k].size(), 0);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        pulse_i        = '0;
        overflow_clr_i = '0;
        for (int k = 0; k < N; k++) sbq[k].delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        r0  = cyc;
    endtask

    function automatic int jit_of(input int ch);
        logic [31:0] x;
        x = {m_lfsr, m_lfsr} >> ch;
        return int'(x[J-1:0]);
    endfunction

    task automatic jitter_run();
        jlat.delete();
        jlog_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            fire(2, 50, 1'b1, 1'b1, 53 + jit_of(2));
            repeat (9) tick();
        end
        drain(100);
        jlog_on = 1'b0;
    endtask

    initial begin
        int         bad, diff;
        logic [7:0] seen;

        vecs[0] = '{0, 10, 13};
        vecs[1] = '{2, 0, 3};
        vecs[2] = '{1, 1, 4};
        vecs[3] = '{3, 200, 203};
        vecs[4] = '{0, 0, 3};
        vecs[5] = '{2, 37, 40};
        vecs[6] = '{1, 2, 5};

        enable_i = '1;
        #1 rst = 1'b1;
        #2;
        check("reset_pulse", int'(pulse_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_ovf", int'(overflow_o), 0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            t = cyc;
            check($sformatf("busy_idle_%0d", i), int'(busy_o[vecs[i].ch]), 0);
            fire(vecs[i].ch, vecs[i].d, 1'b0, 1'b1, vecs[i].lat);
            check($sformatf("busy_rise_%0d", i), int'(busy_o[vecs[i].ch]), 1);
            while (cyc < t + vecs[i].lat) tick();
            check($sformatf("busy_hold_%0d", i), int'(busy_o[vecs[i].ch]), 1);
            tick();
            check($sformatf("busy_fall_%0d", i), int'(busy_o[vecs[i].ch]), 0);
            check($sformatf("vec_done_%0d", i), sbq[vecs[i].ch].size(), 0);
            repeat (3) tick();
        end

        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("ovf_before_drop", int'(overflow_o[1]), 0);
            fire(1, 1000, 1'b0, i < 8, 1003);
            if (i == 8) check("ovf_after_drop", int'(overflow_o[1]), 1);
            else tick();
        end
        tick();
        overflow_clr_i[1] = 1'b1;
        fire(1, 1000, 1'b0, 1'b0, 0);
        check("ovf_set_wins", int'(overflow_o[1]), 1);
        tick();
        overflow_clr_i[1] = 1'b0;
        check("ovf_cleared", int'(overflow_o[1]), 0);
        check("ovf_busy", int'(busy_o[1]), 1);
        drain(1100);
        tick();
        check("ovf_busy_end", int'(busy_o[1]), 0);

        fire(2, 100, 1'b0, 1'b1, 103);
        tick();
        fire(2, 0, 1'b0, 1'b1, 102);
        drain(120);

        for (int i = 0; i < 4; i++) begin
            fire(3, 200, 1'b0, 1'b1, 203);
            tick();
        end
        check("flush_busy_pre", int'(busy_o[3]), 1);
        enable_i[3] = 1'b0;
        sbq[3].delete();
        tick();
        check("flush_busy_post", int'(busy_o[3]), 0);
        fire(3, 5, 1'b0, 1'b0, 0);
        repeat (220) tick();
        check("flush_ovf", int'(overflow_o[3]), 0);
        check("flush_busy_idle", int'(busy_o[3]), 0);
        enable_i[3] = 1'b1;
        tick();
        fire(3, 5, 1'b0, 1'b1, 8);
        drain(20);

        while (cyc < r0 + WRAP_TC) tick();
        fire(0, 2**W - 1, 1'b0, 1'b1, 2**W + 2);
        check("wrap_busy", int'(busy_o[0]), 1);
        drain(2**W + 20);

        do_reset();
        jitter_run();
        check("jitter_count", jlat.size(), 1000);
        bad  = 0;
        seen = '0;
        foreach (jlat[i]) begin
            if (jlat[i] < 53 || jlat[i] > 60) bad++;
            else seen[jlat[i] - 53] = 1'b1;
        end
        check("jitter_range", bad, 0);
        check("jitter_all_values", int'(seen), 255);
        run1 = jlat;
        do_reset();
        jitter_run();
        diff = 0;
        foreach (run1[i])
            if (i >= jlat.size() || jlat[i] != run1[i]) diff++;
        check("jitter_repeat", diff, 0);
        for (int i = 0; i < 200; i++) begin
            fire(2, 50, 1'b0, 1'b1, 53);
            repeat (9) tick();
        end
        drain(100);

        for (int i = 0; i < 9; i++) begin
            fire(1, 1000, 1'b0, 1'b0, 0);
            tick();
        end
        check("mid_ovf_pre", int'(overflow_o[1]), 1);
        t = cyc;
        fire(0, 20, 1'b0, 1'b1, 23);
        while (cyc < t + 23) tick();
        check("mid_pulse_pre", int'(pulse_o[0]), 1);
        rst = 1'b1;
        #1;
        check("async_pulse", int'(pulse_o), 0);
        check("async_busy", int'(busy_o), 0);
        check("async_ovf", int'(overflow_o), 0);
        for (int k = 0; k < N; k++) sbq[k].delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (1100) tick();
        check("post_reset_busy", int'(busy_o), 0);
        check("post_reset_ovf", int'(overflow_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
